// File: rtl/diag_clear_sequencer.sv
// Row-serial diagonal-clear engine: accepts a W x H bit matrix, rewrites one row per
// clock (clearing bit (r,r) unless the diagonal is kept), then presents the result.
module diag_clear_sequencer #(
   parameter int W     = 8,
   parameter int H     = 8,
   parameter int CNT_W = 16,
   localparam int RW   = (W > 1) ? $clog2(W) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W*H-1:0]   in_data,
   input  logic             in_keep_diag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W*H-1:0]   out_data,
   output logic             busy,
   output logic [RW-1:0]    row_idx,
   output logic [CNT_W-1:0] frames_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [W*H-1:0]   src;
   logic [W*H-1:0]   res;
   logic             mode;
   logic             last_row;

   // Copy one row, dropping its diagonal bit; rows with r >= H never match any column.
   function automatic logic [H-1:0] clear_diag(input logic [H-1:0] row, input int r,
                                                input logic keep);
      logic [H-1:0] m;
      m = row;
      for (int j = 0; j < H; j++) begin
         if (!keep && (j == r)) m[j] = 1'b0;
      end
      return m;
   endfunction

   assign last_row = (row_idx == RW'(W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         src         <= '0;
         res         <= '0;
         mode        <= 1'b0;
         row_idx     <= '0;
         frames_done <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  src     <= in_data;
                  mode    <= in_keep_diag;
                  row_idx <= '0;
               end
            end
            RUN: begin
               for (int i = 0; i < W; i++) begin
                  if (row_idx == RW'(i))
                     res[i*H +: H] <= clear_diag(src[i*H +: H], i, mode);
               end
               if (last_row) row_idx <= '0;
               else          row_idx <= row_idx + RW'(1);
            end
            DONE: begin
               if (out_ready) frames_done <= frames_done + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = res;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_row) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_diag_clear_sequencer.sv
// Directed bench for diag_clear_sequencer: an 8x8 instance and a 4x2 instance with a
// 2-bit frame counter, sharing clock and reset.
module tb_diag_clear_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 8x8, 16-bit counter
   logic        a_in_valid, a_in_ready, a_keep, a_out_valid, a_out_ready, a_busy;
   logic [63:0] a_in_data, a_out_data;
   logic [2:0]  a_row_idx;
   logic [15:0] a_frames;

   // 4x2, 2-bit counter
   logic        b_in_valid, b_in_ready, b_keep, b_out_valid, b_out_ready, b_busy;
   logic [7:0]  b_in_data, b_out_data;
   logic [1:0]  b_row_idx;
   logic [1:0]  b_frames;

   int ncmp = 0;
   int nerr = 0;

   diag_clear_sequencer #(.W(8), .H(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_keep_diag(a_keep), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .busy(a_busy), .row_idx(a_row_idx), .frames_done(a_frames)
   );

   diag_clear_sequencer #(.W(4), .H(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_keep_diag(b_keep), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .busy(b_busy), .row_idx(b_row_idx), .frames_done(b_frames)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_reset(input string tag);
      chk({tag, "_in_ready"},  64'(a_in_ready),  64'd1);
      chk({tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
      chk({tag, "_busy"},      64'(a_busy),      64'd0);
      chk({tag, "_row_idx"},   64'(a_row_idx),   64'd0);
      chk({tag, "_frames"},    64'(a_frames),    64'd0);
      chk({tag, "_out_data"},  a_out_data,       64'd0);
   endtask

   logic [1:0] exp_fd [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   initial begin
      a_in_valid = 0; a_keep = 0; a_in_data = '0; a_out_ready = 0;
      b_in_valid = 0; b_keep = 0; b_in_data = '0; b_out_ready = 0;
      step(); step();
      chk_a_reset("reset");
      chk("reset_b_frames", 64'(b_frames), 64'd0);
      rst = 1'b0;
      step();

      // All ones, diagonal cleared
      a_in_data = 64'hFFFF_FFFF_FFFF_FFFF; a_keep = 0; a_in_valid = 1; a_out_ready = 1;
      step();                                   // accept edge T
      a_in_valid = 0;
      chk("t1_busy_after_accept", 64'(a_busy), 64'd1);
      chk("t1_in_ready_after_accept", 64'(a_in_ready), 64'd0);
      repeat (7) step();                        // T+7
      chk("t1_out_valid_early", 64'(a_out_valid), 64'd0);
      step();                                   // T+8
      chk("t1_out_valid", 64'(a_out_valid), 64'd1);
      chk("t1_in_ready_in_done", 64'(a_in_ready), 64'd0);
      chk("t1_out_data", a_out_data, 64'h7FBF_DFEF_F7FB_FDFE);
      step();                                   // handshake
      chk("t1_frames", 64'(a_frames), 64'd1);
      chk("t1_idle_in_ready", 64'(a_in_ready), 64'd1);
      chk("t1_idle_out_valid", 64'(a_out_valid), 64'd0);
      chk("t1_retained_data", a_out_data, 64'h7FBF_DFEF_F7FB_FDFE);

      // Keep diagonal, inputs disturbed during RUN, then back-pressure
      a_in_data = 64'h0123_4567_89AB_CDEF; a_keep = 1; a_in_valid = 1; a_out_ready = 0;
      step();                                   // accept edge T
      a_in_valid = 0; a_in_data = 64'h0; a_keep = 0;
      step(); step(); step();                   // T+3
      chk("t2_row_idx_3", 64'(a_row_idx), 64'd3);
      a_in_data = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (5) step();                        // T+8
      chk("t2_out_valid", 64'(a_out_valid), 64'd1);
      chk("t2_out_data", a_out_data, 64'h0123_4567_89AB_CDEF);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("bp_out_valid", 64'(a_out_valid), 64'd1);
         chk("bp_out_data", a_out_data, 64'h0123_4567_89AB_CDEF);
         chk("bp_busy", 64'(a_busy), 64'd1);
         chk("bp_in_ready", 64'(a_in_ready), 64'd0);
         chk("bp_row_idx", 64'(a_row_idx), 64'd0);
      end
      chk("bp_frames_held", 64'(a_frames), 64'd1);
      a_out_ready = 1;
      step();                                   // handshake
      a_out_ready = 0;
      chk("bp_release_in_ready", 64'(a_in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(a_out_valid), 64'd0);
      chk("bp_release_busy", 64'(a_busy), 64'd0);
      chk("bp_release_frames", 64'(a_frames), 64'd2);

      // Reset mid-RUN
      a_in_data = 64'h5555_5555_5555_5555; a_keep = 1; a_in_valid = 1;
      step();                                   // accept
      a_in_valid = 0;
      step(); step(); step();
      chk("rr_row_idx_3", 64'(a_row_idx), 64'd3);
      rst = 1'b1;
      #1;
      chk_a_reset("rr_async");
      step();
      rst = 1'b0;
      step();
      a_in_data = 64'hFFFF_FFFF_FFFF_FFFF; a_keep = 0; a_in_valid = 1; a_out_ready = 1;
      step();                                   // accept
      a_in_valid = 0;
      repeat (8) step();
      chk("rr_out_valid", 64'(a_out_valid), 64'd1);
      chk("rr_out_data", a_out_data, 64'h7FBF_DFEF_F7FB_FDFE);
      step();
      chk("rr_frames", 64'(a_frames), 64'd1);

      // Non-square 4x2, back-to-back frames through a 2-bit counter
      b_in_data = 8'hFF; b_keep = 0; b_in_valid = 1; b_out_ready = 1;
      for (int f = 0; f < 5; f++) begin
         step();                                // accept
         chk("b_in_ready_after_accept", 64'(b_in_ready), 64'd0);
         repeat (3) step();
         chk("b_out_valid_early", 64'(b_out_valid), 64'd0);
         step();
         chk("b_out_valid", 64'(b_out_valid), 64'd1);
         chk("b_out_data", 64'(b_out_data), 64'h0F6);
         step();                                // handshake
         chk("b_frames_done", 64'(b_frames), 64'(exp_fd[f]));
         chk("b_in_ready_idle", 64'(b_in_ready), 64'd1);
      end
      b_in_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
